// File: rtl/bcd_to_binary_entry_if.sv
// Entry-side bundle for bcd_to_binary_entry: request/handshake, result and status.
// hex_digits exists only when BCD_ENTRY_HEX_DISPLAY_EN is defined.
interface bcd_to_binary_entry_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned WIDTH  = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  valid;
    logic [WIDTH-1:0]      binary;
    logic                  overload;
    logic                  invalid_digit;
    logic [4*DIGITS-1:0]   led;
`ifdef BCD_ENTRY_HEX_DISPLAY_EN
    logic [13:0]           hex_digits;
`endif

`ifdef BCD_ENTRY_HEX_DISPLAY_EN
    modport master (
        output start, bcd_in,
        input  busy, valid, binary, overload, invalid_digit, led, hex_digits
    );

    modport slave (
        input  start, bcd_in,
        output busy, valid, binary, overload, invalid_digit, led, hex_digits
    );
`else
    modport master (
        output start, bcd_in,
        input  busy, valid, binary, overload, invalid_digit, led
    );

    modport slave (
        input  start, bcd_in,
        output busy, valid, binary, overload, invalid_digit, led
    );
`endif
endinterface

// File: rtl/bcd_to_binary_entry.sv
// Iterative BCD-to-binary converter (reverse double-dabble) with start/busy/valid handshake.
// Optional 7-segment result display enabled by defining BCD_ENTRY_HEX_DISPLAY_EN.
module bcd_to_binary_entry #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    bcd_to_binary_entry_if.slave bus
);

    localparam int unsigned NB = 4 * DIGITS;
    localparam int unsigned CW = $clog2(NB + 1);
    localparam int unsigned RW = (NB > WIDTH) ? NB : WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [2*NB-1:0] work;
    logic [2*NB-1:0] work_next;
    logic [CW-1:0]   count;
    logic            bad;

    logic            start_bad;
    logic [RW-1:0]   result_ext;
    logic            result_over;
    logic [WIDTH-1:0] result_bin;

    always_comb begin
        start_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                start_bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then correct any BCD nibble >= 8 by -3.
    always_comb begin
        work_next = work >> 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work_next[NB + 4*i + 3]) begin
                work_next[NB + 4*i +: 4] = work_next[NB + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        result_ext  = RW'(work[NB-1:0]);
        result_over = |(result_ext >> WIDTH);
        result_bin  = result_ext[WIDTH-1:0];
    end

`ifdef BCD_ENTRY_HEX_DISPLAY_EN
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0:    on = 7'h3F;
            4'h1:    on = 7'h06;
            4'h2:    on = 7'h5B;
            4'h3:    on = 7'h4F;
            4'h4:    on = 7'h66;
            4'h5:    on = 7'h6D;
            4'h6:    on = 7'h7D;
            4'h7:    on = 7'h07;
            4'h8:    on = 7'h7F;
            4'h9:    on = 7'h6F;
            4'hA:    on = 7'h77;
            4'hB:    on = 7'h7C;
            4'hC:    on = 7'h39;
            4'hD:    on = 7'h5E;
            4'hE:    on = 7'h79;
            default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    logic [7:0]  disp_val;
    logic [13:0] hex_next;

    always_comb begin
        disp_val = 8'(result_bin);
        if (bad) begin
            hex_next = {SEG_DASH, SEG_DASH};
        end else if (result_over) begin
            hex_next = {SEG_F, SEG_F};
        end else begin
            hex_next = {seg7(disp_val[7:4]), seg7(disp_val[3:0])};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.hex_digits <= {SEG_BLANK, SEG_BLANK};
        end else if (state == DONE) begin
            bus.hex_digits <= hex_next;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            work              <= '0;
            count             <= '0;
            bad               <= 1'b0;
            bus.busy          <= 1'b0;
            bus.valid         <= 1'b0;
            bus.binary        <= '0;
            bus.overload      <= 1'b0;
            bus.invalid_digit <= 1'b0;
            bus.led           <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work     <= {bus.bcd_in, {NB{1'b0}}};
                        bus.led  <= bus.bcd_in;
                        count    <= '0;
                        bad      <= start_bad;
                        bus.busy <= 1'b1;
                        state    <= start_bad ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    work  <= work_next;
                    count <= count + 1'b1;
                    if (count == CW'(NB - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The edge leaving DONE publishes the result, so busy drops as valid rises.
                    state     <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.valid <= 1'b1;
                    if (bad) begin
                        bus.binary        <= '0;
                        bus.overload      <= 1'b0;
                        bus.invalid_digit <= 1'b1;
                    end else if (result_over) begin
                        bus.binary        <= '1;
                        bus.overload      <= 1'b1;
                        bus.invalid_digit <= 1'b0;
                    end else begin
                        bus.binary        <= result_bin;
                        bus.overload      <= 1'b0;
                        bus.invalid_digit <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_entry.sv
// Directed-vector bench for bcd_to_binary_entry (DIGITS=3, WIDTH=8).
module tb_bcd_to_binary_entry;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    bcd_to_binary_entry_if #(.DIGITS(3), .WIDTH(8)) bus ();

    bcd_to_binary_entry #(.DIGITS(3), .WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Pulses start for one edge and waits for valid; lat counts edges after the accepting one.
    task automatic convert(input string tag, input logic [11:0] bcd, input logic [7:0] exp_bin,
                           input logic exp_ovl, input logic exp_inv, input int lat);
        int  n;
        bit  seen;
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check({tag, ".busy_on"}, 32'(bus.busy), 1);
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clock); #1;
            n++;
            if (n == lat - 1) check({tag, ".busy_mid"}, 32'(bus.busy), 1);
            if (bus.valid) seen = 1;
        end
        check({tag, ".latency"}, 32'(n), 32'(lat));
        check({tag, ".binary"}, 32'(bus.binary), 32'(exp_bin));
        check({tag, ".overload"}, 32'(bus.overload), 32'(exp_ovl));
        check({tag, ".invalid"}, 32'(bus.invalid_digit), 32'(exp_inv));
        check({tag, ".led"}, 32'(bus.led), 32'(bcd));
        @(posedge clock); #1;
        check({tag, ".valid_off"}, 32'(bus.valid), 0);
        check({tag, ".busy_off"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int nvalid;
        int vedge [4];
        logic [7:0]  vbin;
        logic [11:0] vled;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.bcd_in  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.valid", 32'(bus.valid), 0);
        check("rst.binary", 32'(bus.binary), 0);
        check("rst.overload", 32'(bus.overload), 0);
        check("rst.invalid", 32'(bus.invalid_digit), 0);
        check("rst.led", 32'(bus.led), 0);
`ifdef BCD_ENTRY_HEX_DISPLAY_EN
        check("rst.hex", 32'(bus.hex_digits), 'h3FFF);
`endif
        reset = 1'b1;
        @(posedge clock); #1;

        // Abort after five iterations of 123.
        bus.bcd_in = 12'h123;
        bus.start  = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 0);
        check("abort.led", 32'(bus.led), 0);
        check("abort.binary", 32'(bus.binary), 0);
        @(posedge clock); #1;
        reset  = 1'b1;
        nvalid = 0;
        repeat (16) begin
            @(posedge clock); #1;
            if (bus.valid) nvalid++;
        end
        check("abort.no_valid", 32'(nvalid), 0);
        convert("v045", 12'h045, 8'h2D, 1'b0, 1'b0, 13);

        convert("v255", 12'h255, 8'hFF, 1'b0, 1'b0, 13);
        convert("v256", 12'h256, 8'hFF, 1'b1, 1'b0, 13);
`ifdef BCD_ENTRY_HEX_DISPLAY_EN
        check("v256.hex", 32'(bus.hex_digits), 32'({7'b0001110, 7'b0001110}));
`endif
        convert("v999", 12'h999, 8'hFF, 1'b1, 1'b0, 13);
        convert("v000", 12'h000, 8'h00, 1'b0, 1'b0, 13);
        convert("v1A3", 12'h1A3, 8'h00, 1'b0, 1'b1, 1);
`ifdef BCD_ENTRY_HEX_DISPLAY_EN
        check("v1A3.hex", 32'(bus.hex_digits), 32'({7'b0111111, 7'b0111111}));
`endif
        convert("v100", 12'h100, 8'h64, 1'b0, 1'b0, 13);
        convert("v009", 12'h009, 8'h09, 1'b0, 1'b0, 13);
        convert("v187", 12'h187, 8'hBB, 1'b0, 1'b0, 13);

        // Start pulses and bcd_in changes while busy must be ignored.
        bus.bcd_in = 12'h099;
        bus.start  = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        nvalid    = 0;
        vedge[0]  = -1;
        vbin      = '0;
        vled      = '0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clock); #1;
            if (bus.valid) begin
                nvalid++;
                vedge[0] = i;
                vbin     = bus.binary;
                vled     = bus.led;
            end
            if (i == 2 || i == 7) begin
                bus.start  = 1'b1;
                bus.bcd_in = 12'h200;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("busy_ign.count", 32'(nvalid), 1);
        check("busy_ign.edge", 32'(vedge[0]), 13);
        check("busy_ign.binary", 32'(vbin), 'h63);
        check("busy_ign.led", 32'(vled), 'h099);

        // Start held high retriggers every 14 cycles.
        bus.bcd_in = 12'h128;
        bus.start  = 1'b1;
        nvalid     = 0;
        for (int i = 0; i < 4; i++) vedge[i] = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            if (bus.valid) begin
                if (nvalid < 4) vedge[nvalid] = i;
                nvalid++;
                check("held.binary", 32'(bus.binary), 'h80);
`ifdef BCD_ENTRY_HEX_DISPLAY_EN
                check("held.hex", 32'(bus.hex_digits), 32'({7'b0000000, 7'b1000000}));
`endif
            end
            if (i == 39) bus.start = 1'b0;
        end
        check("held.count", 32'(nvalid), 3);
        check("held.edge0", 32'(vedge[0]), 13);
        check("held.edge1", 32'(vedge[1]), 27);
        check("held.edge2", 32'(vedge[2]), 41);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_entry.md
Name: bcd_to_binary_entry

Overview:
- Inverse of the team's hex-to-decimal display path: converts a user-entered decimal (BCD) value into an 8-bit binary result.
- Typical use: switches/digit entry -> this block -> hex display and downstream logic.
- Iterative reverse double-dabble engine (shift right, subtract 3) under a small FSM. Start/busy/valid handshake; overload and invalid-digit flags.

Parameters:
- DIGITS, 3, number of BCD input digits (range 1-4).
- WIDTH, 8, binary result width; result saturates above 2^WIDTH-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  BCD value, digit 0 in bits [3:0]; sampled on the accepted start edge only.
- busy  output  1  high from the accepting edge until the edge that leaves DONE.
- valid  output  1  one-cycle pulse; result outputs are updated on the same edge.
- binary  output  WIDTH  converted value, held until the next valid.
- overload  output  1  value exceeded 2^WIDTH-1 (binary saturated); held with binary.
- invalid_digit  output  1  some input nibble >9; held with binary.
- led  output  4*DIGITS  registered copy of the last accepted bcd_in.

Behaviour:
- Reset (reset low, asynchronous): FSM=IDLE; busy, valid, overload, invalid_digit = 0; binary = 0; led = 0; internal shift register and counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - latch bcd_in into the BCD half of an 8*DIGITS-bit work register; clear the binary half.
  - copy bcd_in to led; counter = 0; busy = 1.
  - If any nibble >9: set the internal invalid flag and go to DONE (no iterations). Otherwise go to SHIFT.
- IDLE, start=0: hold all outputs.
- SHIFT (one iteration per clock):
  - shift the whole work register right by 1; BCD LSB moves into binary MSB.
  - then, for every BCD nibble with value >=8, subtract 3 (same cycle, combinational after the shift).
  - counter increments. After 4*DIGITS iterations, go to DONE.
- DONE, one cycle:
  - valid = 1.
  - invalid: binary = 0, invalid_digit = 1, overload = 0.
  - else if the full 4*DIGITS-bit result > 2^WIDTH-1: binary = all ones, overload = 1, invalid_digit = 0.
  - else: binary = result[WIDTH-1:0]; both flags = 0.
  - Next edge: IDLE, busy = 0, valid = 0.
- Latency: start accepted at edge N -> valid high after edge N+4*DIGITS+1 (N+13 for DIGITS=3). Invalid input: valid after edge N+1.
- start while busy is ignored; bcd_in changes while busy are ignored.
- start asserted in the same cycle busy falls is not accepted; it must be seen while in IDLE.
- Back-to-back: start held high re-triggers on the first IDLE cycle; minimum spacing is 4*DIGITS+2 cycles.
- Reset mid-conversion: immediate abort to the reset values; no valid pulse.
- Result outputs change only on valid edges or reset.

Optional Feature:
- Macro: BCD_ENTRY_HEX_DISPLAY_EN.
- Defined:
  - adds output hex_digits [13:0]: two active-low 7-segment patterns of binary[7:4] ([13:7]) and binary[3:0] ([6:0]), registered and updated with valid.
  - during overload, both digits show "F"; during invalid_digit, both show "-" (segment g only).
  - reset value: both digits blank (all segments off = 7'b1111111).
- Not defined: port absent, no segment logic; all other behaviour identical.

Test Plan:
- Reset low mid-SHIFT (after 5 iterations of bcd_in=12'h123) -> all outputs 0 immediately; no valid; next start with 12'h045 -> binary=8'h2D after 13 cycles.
- bcd_in=12'h255, start pulse at edge N -> busy N..N+13, valid one cycle after edge N+13, binary=8'hFF, overload=0, invalid_digit=0.
- bcd_in=12'h256, then 12'h999 -> binary=8'hFF with overload=1 for both; 12'h000 afterward -> binary=8'h00, overload=0.
- bcd_in=12'h1A3 -> valid after edge N+1, invalid_digit=1, binary=8'h00; with BCD_ENTRY_HEX_DISPLAY_EN, hex_digits shows "-" "-".
- bcd_in=12'h099, then start re-pulsed at N+3 and N+8 with bcd_in=12'h200 -> both ignored; single valid with binary=8'h63, led=12'h099.
- start held high for 40 cycles with bcd_in=12'h128 -> valid pulses every 14 cycles, binary=8'h80 each time; with the macro, hex_digits = "8","0".
